// File: rtl/wb_writeback.sv
// Writeback stage: merges buffered ALU results and a single outstanding load onto
// the register-file write port. Define WB_BYPASS_EN to let uncontended ALU results skip the buffer.
module wb_writeback #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue_valid,
  output logic                  ld_issue_ready,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic [2:0]            ld_issue_funct3,
  input  logic [1:0]            ld_issue_addr_lo,
  input  logic                  ld_resp_valid,
  input  logic [XLEN-1:0]       ld_resp_data,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  rd_en,
  output logic [XLEN-1:0]       rd_data,
  output logic [31:0]           sb_busy
);

  // state     | meaning
  // ST_IDLE   | no load outstanding, new load may issue
  // ST_WAIT   | load issued, waiting for memory response
  // ST_WRITE  | formatted load data owns the write port this cycle
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [1:0]            state;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [2:0]            ld_funct3;
  logic [1:0]            ld_addr_lo;
  logic [XLEN-1:0]       ld_data;

  logic [REG_ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  logic       fifo_full;
  logic       fifo_empty;
  logic       alu_fire;
  logic       bypass;
  logic       push;
  logic       pop;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [XLEN-1:0] ld_fmt;

  assign fifo_full      = (count == DEPTH_C);
  assign fifo_empty     = (count == '0);
  assign alu_ready      = !fifo_full;
  assign ld_issue_ready = (state == ST_IDLE);
  assign alu_fire       = alu_valid && alu_ready;
  assign pop            = !fifo_empty && (state != ST_WRITE);

`ifdef WB_BYPASS_EN
  assign bypass = alu_fire && fifo_empty && (state != ST_WRITE);
`else
  assign bypass = 1'b0;
`endif

  assign push = alu_fire && !bypass;

  always_comb begin
    ld_byte = ld_resp_data[7:0];
    case (ld_addr_lo)
      2'd1:    ld_byte = ld_resp_data[15:8];
      2'd2:    ld_byte = ld_resp_data[23:16];
      2'd3:    ld_byte = ld_resp_data[31:24];
      default: ld_byte = ld_resp_data[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? ld_resp_data[31:16] : ld_resp_data[15:0];
    case (ld_funct3)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_fmt = ld_resp_data;
    endcase
  end

  // buffer storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ld_rd      <= '0;
      ld_funct3  <= '0;
      ld_addr_lo <= '0;
      ld_data    <= '0;
      sb_busy    <= '0;
      rd         <= '0;
      rd_en      <= 1'b0;
      rd_data    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_issue_valid) begin
            state      <= ST_WAIT;
            ld_rd      <= ld_issue_rd;
            ld_funct3  <= ld_issue_funct3;
            ld_addr_lo <= ld_issue_addr_lo;
            if (ld_issue_rd != '0) sb_busy[ld_issue_rd] <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (ld_resp_valid) begin
            state   <= ST_WRITE;
            ld_data <= ld_fmt;
          end
        end
        ST_WRITE: begin
          state          <= ST_IDLE;
          sb_busy[ld_rd] <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // the load result always has priority over buffered ALU results
      if (state == ST_WRITE) begin
        rd      <= ld_rd;
        rd_data <= ld_data;
        rd_en   <= (ld_rd != '0);
      end else if (pop) begin
        rd      <= fifo_rd[rd_ptr];
        rd_data <= fifo_data[rd_ptr];
        rd_en   <= (fifo_rd[rd_ptr] != '0);
      end else if (bypass) begin
        rd      <= alu_rd;
        rd_data <= alu_data;
        rd_en   <= (alu_rd != '0);
      end else begin
        rd_en <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_writeback.sv
// Self-checking bench for wb_writeback: queue-based reference model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_wb_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic [2:0]  ld_issue_funct3;
  logic [1:0]  ld_issue_addr_lo;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [4:0]  rd;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [31:0] sb_busy;

  always #5 clk = ~clk;

  wb_writeback dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
    .ld_issue_rd(ld_issue_rd), .ld_issue_funct3(ld_issue_funct3),
    .ld_issue_addr_lo(ld_issue_addr_lo),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .rd(rd), .rd_en(rd_en), .rd_data(rd_data), .sb_busy(sb_busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] lo,
                                      input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lo)) & 32'hff;
    h = (w >> (16 * lo[1])) & 32'hffff;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hffffff00) : b;
      3'b001:  return h[15] ? (h | 32'hffff0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  // reference model: ALU results wait in a queue, the load walks idle/waiting/ready
  ent_t        alu_q[$];
  wr_t         wlog[$];
  int          ld_phase = 0;
  logic [4:0]  m_ld_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_lo;
  logic [31:0] m_ld_val;
  logic        m_en = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_busy = '0;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    int   old_phase;
    bit   acc;
    bit   wrote;
    ent_t e;
    model_valid = 1'b1;
    cyc++;
    if (reset) begin
      alu_q.delete();
      ld_phase = 0;
      m_en = 1'b0;
      m_rd = '0;
      m_data = '0;
      m_busy = '0;
    end else begin
      old_phase = ld_phase;
      acc = alu_valid && (alu_q.size() < DEPTH);
      wrote = 1'b0;
      if (old_phase == 2) begin
        m_rd = m_ld_rd; m_data = m_ld_val; m_en = (m_ld_rd != 0);
        m_busy[m_ld_rd] = 1'b0;
        ld_phase = 0;
        wrote = 1'b1;
      end else if (alu_q.size() > 0) begin
        e = alu_q.pop_front();
        m_rd = e.rd; m_data = e.data; m_en = (e.rd != 0);
        wrote = 1'b1;
      end
`ifdef WB_BYPASS_EN
      else if (acc) begin
        m_rd = alu_rd; m_data = alu_data; m_en = (alu_rd != 0);
        acc = 1'b0;
        wrote = 1'b1;
      end
`endif
      if (!wrote) m_en = 1'b0;
      if (acc) alu_q.push_back('{alu_rd, alu_data});
      if (old_phase == 0 && ld_issue_valid) begin
        ld_phase = 1;
        m_ld_rd = ld_issue_rd; m_f3 = ld_issue_funct3; m_lo = ld_issue_addr_lo;
        if (ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
      end else if (old_phase == 1 && ld_resp_valid) begin
        ld_phase = 2;
        m_ld_val = fmt(m_f3, m_lo, ld_resp_data);
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("alu_ready", {31'b0, alu_ready}, {31'b0, alu_q.size() < DEPTH});
      check("ld_issue_ready", {31'b0, ld_issue_ready}, {31'b0, ld_phase == 0});
      check("rd_en", {31'b0, rd_en}, {31'b0, m_en});
      check("sb_busy", sb_busy, m_busy);
      if (m_en) begin
        check("rd", {27'b0, rd}, {27'b0, m_rd});
        check("rd_data", rd_data, m_data);
      end
      if (rd_en) wlog.push_back('{rd, rd_data, cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] lo);
    ld_issue_valid = 1'b1; ld_issue_rd = r; ld_issue_funct3 = f3; ld_issue_addr_lo = lo;
    tick();
    ld_issue_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  idx;
    int  guard;
    bit  stall_seen;
    bit  acc;
    int  n8;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0; ld_issue_funct3 = 0; ld_issue_addr_lo = 0;
    ld_resp_valid = 0; ld_resp_data = 0;

    // reset
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_rd_en", {31'b0, rd_en}, 32'd0);
    check("rst_sb_busy", sb_busy, 32'd0);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    check("rst_ld_issue_ready", {31'b0, ld_issue_ready}, 32'd1);
    check("rst_rd", {27'b0, rd}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);

    // single ALU write latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
`ifdef WB_BYPASS_EN
    check("alu_lat_en", {31'b0, rd_en}, 32'd1);
    check("alu_lat_rd", {27'b0, rd}, 32'd5);
    check("alu_lat_data", rd_data, 32'hDEADBEEF);
    tick();
    check("alu_pulse_end", {31'b0, rd_en}, 32'd0);
`else
    check("alu_lat_early", {31'b0, rd_en}, 32'd0);
    tick();
    check("alu_lat_en", {31'b0, rd_en}, 32'd1);
    check("alu_lat_rd", {27'b0, rd}, 32'd5);
    check("alu_lat_data", rd_data, 32'hDEADBEEF);
    tick();
    check("alu_pulse_end", {31'b0, rd_en}, 32'd0);
`endif

    // LB with sign extension, scoreboard lifetime
    issue(5'd7, 3'b000, 2'd2);
    check("lb_busy_set", {31'b0, sb_busy[7]}, 32'd1);
    check("lb_issue_ready", {31'b0, ld_issue_ready}, 32'd0);
    tick(); tick();
    check("lb_busy_hold", {31'b0, sb_busy[7]}, 32'd1);
    ld_resp_valid = 1'b1; ld_resp_data = 32'h1280FF00;
    tick();
    ld_resp_valid = 1'b0;
    check("lb_m1_en", {31'b0, rd_en}, 32'd0);
    check("lb_m1_busy", {31'b0, sb_busy[7]}, 32'd1);
    tick();
    check("lb_en", {31'b0, rd_en}, 32'd1);
    check("lb_rd", {27'b0, rd}, 32'd7);
    check("lb_data", rd_data, 32'hFFFFFF80);
    check("lb_busy_clr", {31'b0, sb_busy[7]}, 32'd0);
    tick();
    check("lb_pulse_end", {31'b0, rd_en}, 32'd0);

    // LHU
    issue(5'd9, 3'b101, 2'd2);
    ld_resp_valid = 1'b1; ld_resp_data = 32'h80010000;
    tick();
    ld_resp_valid = 1'b0;
    tick();
    check("lhu_en", {31'b0, rd_en}, 32'd1);
    check("lhu_rd", {27'b0, rd}, 32'd9);
    check("lhu_data", rd_data, 32'h00008001);
    tick();

    // load response contending with three back-to-back ALU results
    wlog.delete();
    issue(5'd3, 3'b010, 2'd1);
    tick();
    ld_resp_valid = 1'b1; ld_resp_data = 32'h0BADF00D;
`ifdef WB_BYPASS_EN
    tick();
    ld_resp_valid = 1'b0;
`endif
    idx = 0; guard = 0; stall_seen = 1'b0;
    while (idx < 3 && guard < 20) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + idx); alu_data = 32'hA0 + 32'(idx);
      if (!alu_ready) stall_seen = 1'b1;
      acc = alu_ready;
      tick();
      ld_resp_valid = 1'b0;
      if (acc) idx++;
      guard++;
    end
    alu_valid = 1'b0;
    check("cont_all_accepted", 32'(idx), 32'd3);
    repeat (6) tick();
`ifndef WB_BYPASS_EN
    check("cont_stall_seen", {31'b0, stall_seen}, 32'd1);
`endif
    check("cont_writes", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      check("cont_w0_rd", {27'b0, wlog[0].rd}, 32'd3);
      check("cont_w0_data", wlog[0].data, 32'h0BADF00D);
      for (int i = 1; i < 4; i++) begin
        check("cont_wi_rd", {27'b0, wlog[i].rd}, 32'(9 + i));
        check("cont_wi_data", wlog[i].data, 32'hA0 + 32'(i - 1));
        check("cont_wi_cyc", 32'(wlog[i].cyc), 32'(wlog[0].cyc + i));
      end
    end

    // rd==0 results are consumed silently
    wlog.delete();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd0; ld_issue_funct3 = 3'b010; ld_issue_addr_lo = 2'd0;
    tick();
    ld_issue_valid = 1'b0;
    check("x0_busy", sb_busy, 32'd0);
    alu_data = 32'h2;
    ld_resp_valid = 1'b1; ld_resp_data = 32'h55555555;
    tick();
    ld_resp_valid = 1'b0;
    alu_rd = 5'd6; alu_data = 32'h3;
    tick();
    alu_valid = 1'b0;
    repeat (6) tick();
    check("x0_writes", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) begin
      check("x0_w_rd", {27'b0, wlog[0].rd}, 32'd6);
      check("x0_w_data", wlog[0].data, 32'h3);
    end
    check("x0_busy_end", sb_busy, 32'd0);

    // reset drops a queued ALU result
    wlog.delete();
    issue(5'd4, 3'b010, 2'd0);
    ld_resp_valid = 1'b1; ld_resp_data = 32'h12345678;
    tick();
    ld_resp_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    tick();
    alu_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    n8 = 0;
    foreach (wlog[i]) if (wlog[i].rd == 5'd8) n8++;
    check("rst_drop_alu", 32'(n8), 32'd0);

    // reset while waiting for a response, then a late response
    wlog.delete();
    issue(5'd4, 3'b000, 2'd0);
    check("rstw_busy_set", {31'b0, sb_busy[4]}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw_issue_ready", {31'b0, ld_issue_ready}, 32'd1);
    check("rstw_busy", sb_busy, 32'd0);
    ld_resp_valid = 1'b1; ld_resp_data = 32'hFFFFFFFF;
    tick();
    ld_resp_valid = 1'b0;
    repeat (3) tick();
    check("rstw_no_write", 32'(wlog.size()), 32'd0);
    check("rstw_issue_ready_end", {31'b0, ld_issue_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
